// File: rtl/result_collector_if.sv
// result_collector_if: groups the capture/pop handshake and the drain-side
// outputs of result_collector.
//   master : producer/consumer side (drives clr, captureEn, shiftRegIn, rdEn)
//   slave  : the collector (drives bufferOut, valid, full, count, overflow, tileDone)
// Lane i of a window lives in shiftRegIn[i] / bufferOut[i]; lane 0 is the
// most significant byte of the packed 32-bit value.
interface result_collector_if #(
  parameter int unsigned DEPTH = 8
);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic             clr;
  logic             captureEn;
  logic [0:3][7:0]  shiftRegIn;
  logic             rdEn;
  logic [0:3][7:0]  bufferOut;
  logic             valid;
  logic             full;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             tileDone;

  modport master (
    output clr, captureEn, shiftRegIn, rdEn,
    input  bufferOut, valid, full, count, overflow, tileDone
  );

  modport slave (
    input  clr, captureEn, shiftRegIn, rdEn,
    output bufferOut, valid, full, count, overflow, tileDone
  );
endinterface

// File: rtl/result_collector.sv
// result_collector: captures 4 x 8-bit PE2 output windows into a
// first-word-fall-through buffer and presents the head entry in the shape of
// the next layer's bufferInput port. A 16-bit tile counter pulses tileDone
// when TILES entries have been popped.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous reset, active-high
//   bus  : result_collector_if.slave (clr, captureEn, shiftRegIn, rdEn in;
//          bufferOut, valid, full, count, overflow, tileDone out)
// Parameters:
//   DEPTH : entries in the buffer, power of two, >= 2
//   TILES : popped entries per tile, 1..65535
module result_collector #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned TILES = 16
) (
  input  logic              clk,
  input  logic              rst,
  result_collector_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned TW = 16;

  logic [0:3][7:0] mem [DEPTH];
  logic [AW-1:0]   wptr;
  logic [AW-1:0]   rptr;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_nxt;
  logic [TW-1:0]   tile_cnt;
  logic            valid_q;
  logic            full_q;
  logic            ovf_q;
  logic            tdone_q;
  logic            pop_ok;
  logic            push_ok;

  // A capture into a full buffer still fits when a pop frees a slot the same
  // cycle; a pop on an empty buffer is ignored even if a capture arrives.
  assign pop_ok  = bus.rdEn && (cnt != '0);
  assign push_ok = bus.captureEn && ((cnt != CW'(DEPTH)) || pop_ok);

  // Occupancy after this cycle's accepted capture/pop.
  always_comb begin
    cnt_nxt = cnt;
    if (push_ok && !pop_ok) begin
      cnt_nxt = cnt + CW'(1);
    end else if (pop_ok && !push_ok) begin
      cnt_nxt = cnt - CW'(1);
    end
  end

  // Data array: no reset, contents are don't-care while not occupied.
  always_ff @(posedge clk) begin
    if (push_ok && !bus.clr) begin
      mem[wptr] <= bus.shiftRegIn;
    end
  end

  // Pointers, occupancy, flags and tile counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr     <= '0;
      rptr     <= '0;
      cnt      <= '0;
      valid_q  <= 1'b0;
      full_q   <= 1'b0;
      ovf_q    <= 1'b0;
      tile_cnt <= '0;
      tdone_q  <= 1'b0;
    end else if (bus.clr) begin
      wptr     <= '0;
      rptr     <= '0;
      cnt      <= '0;
      valid_q  <= 1'b0;
      full_q   <= 1'b0;
      ovf_q    <= 1'b0;
      tile_cnt <= '0;
      tdone_q  <= 1'b0;
    end else begin
      tdone_q <= 1'b0;
      if (push_ok) begin
        wptr <= wptr + AW'(1);
      end
      if (pop_ok) begin
        rptr <= rptr + AW'(1);
      end
      cnt     <= cnt_nxt;
      valid_q <= (cnt_nxt != '0);
      full_q  <= (cnt_nxt == CW'(DEPTH));
      if (bus.captureEn && !push_ok) begin
        ovf_q <= 1'b1;
      end
      if (pop_ok) begin
        if (tile_cnt == TW'(TILES - 1)) begin
          tile_cnt <= '0;
          tdone_q  <= 1'b1;
        end else begin
          tile_cnt <= tile_cnt + TW'(1);
        end
      end
    end
  end

  // Fall-through head: read straight from the array, zero while empty.
  assign bus.bufferOut = valid_q ? mem[rptr] : '0;
  assign bus.valid     = valid_q;
  assign bus.full      = full_q;
  assign bus.count     = cnt;
  assign bus.overflow  = ovf_q;
  assign bus.tileDone  = tdone_q;
endmodule

// File: tb/tb_result_collector.sv
// Scoreboard bench for result_collector (DEPTH=8, TILES=4).
module tb_result_collector;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned TILES = 4;

  logic clk;
  logic rst;
  result_collector_if #(.DEPTH(DEPTH)) m ();

  result_collector #(.DEPTH(DEPTH), .TILES(TILES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (m)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] q[$];
  bit          m_ovf;
  int          m_tile;
  bit          m_tdone;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle();
    m.clr        = 1'b0;
    m.captureEn  = 1'b0;
    m.shiftRegIn = '0;
    m.rdEn       = 1'b0;
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf   = 1'b0;
    m_tile  = 0;
    m_tdone = 1'b0;
  endtask

  // One clock cycle: drive, check head, update model, clock, check state.
  task automatic step(input bit cap, input logic [31:0] d, input bit rd, input bit clr_i = 1'b0);
    bit pop_ok;
    bit push_ok;
    m.clr        = clr_i;
    m.captureEn  = cap;
    m.shiftRegIn = d;
    m.rdEn       = rd;
    if (q.size() > 0) chk("head", m.bufferOut, q[0]);
    else              chk("head_empty", m.bufferOut, 32'h0);
    if (clr_i) begin
      model_reset();
    end else begin
      pop_ok  = rd && (q.size() > 0);
      push_ok = cap && ((q.size() < DEPTH) || pop_ok);
      m_tdone = 1'b0;
      if (cap && !push_ok) m_ovf = 1'b1;
      if (pop_ok) begin
        void'(q.pop_front());
        if (m_tile == TILES - 1) begin
          m_tile  = 0;
          m_tdone = 1'b1;
        end else begin
          m_tile++;
        end
      end
      if (push_ok) q.push_back(d);
    end
    @(posedge clk);
    #1;
    chk("count",    32'(m.count),    32'(q.size()));
    chk("valid",    32'(m.valid),    32'(q.size() > 0));
    chk("full",     32'(m.full),     32'(q.size() == DEPTH));
    chk("overflow", 32'(m.overflow), 32'(m_ovf));
    chk("tileDone", 32'(m.tileDone), 32'(m_tdone));
    chk("tile_cnt", 32'(dut.tile_cnt), 32'(m_tile));
  endtask

  initial begin
    int pulses;
    idle();
    model_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count",    32'(m.count),    32'h0);
    chk("rst_valid",    32'(m.valid),    32'h0);
    chk("rst_full",     32'(m.full),     32'h0);
    chk("rst_overflow", 32'(m.overflow), 32'h0);
    chk("rst_tileDone", 32'(m.tileDone), 32'h0);
    chk("rst_bufout",   m.bufferOut,     32'h0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Single capture then pop
    step(1'b1, 32'h11223344, 1'b0);
    chk("single_head",  m.bufferOut,     32'h11223344);
    chk("single_count", 32'(m.count),    32'd1);
    step(1'b0, 32'h0, 1'b1);
    chk("single_drain", m.bufferOut,     32'h0);

    // Fill to full, one dropped capture, drain in order
    for (int k = 0; k < 9; k++) step(1'b1, {8'(k), 24'h0}, 1'b0);
    chk("fill_full",     32'(m.full),     32'h1);
    chk("fill_overflow", 32'(m.overflow), 32'h1);
    for (int k = 0; k < 8; k++) begin
      chk("fill_order", m.bufferOut, {8'(k), 24'h0});
      step(1'b0, 32'h0, 1'b1);
    end
    chk("ovf_sticky", 32'(m.overflow), 32'h1);
    step(1'b0, 32'h0, 1'b1);
    step(1'b0, 32'h0, 1'b0, 1'b1);
    chk("clr_overflow", 32'(m.overflow), 32'h0);

    // Wrap-around of both pointers
    for (int k = 0; k < 5; k++) step(1'b1, 32'hA000_0000 + 32'(k), 1'b0);
    for (int k = 0; k < 5; k++) step(1'b0, 32'h0, 1'b1);
    for (int k = 0; k < 6; k++) step(1'b1, 32'hB000_0000 + 32'(k), 1'b0);
    for (int k = 0; k < 6; k++) step(1'b0, 32'h0, 1'b1);
    chk("wrap_empty", 32'(m.count), 32'h0);

    // Simultaneous capture+pop when full, then when empty
    for (int k = 0; k < 8; k++) step(1'b1, 32'hC000_0000 + 32'(k), 1'b0);
    step(1'b1, 32'hCAFE_F00D, 1'b1);
    chk("full_sim_count", 32'(m.count),    32'd8);
    chk("full_sim_ovf",   32'(m.overflow), 32'h0);
    for (int k = 0; k < 7; k++) step(1'b0, 32'h0, 1'b1);
    chk("full_sim_8th", m.bufferOut, 32'hCAFE_F00D);
    step(1'b0, 32'h0, 1'b1);
    step(1'b1, 32'h5A5A_A5A5, 1'b1);
    chk("empty_sim_count", 32'(m.count), 32'd1);
    chk("empty_sim_head",  m.bufferOut,  32'h5A5A_A5A5);
    step(1'b0, 32'h0, 1'b1);

    // Tile boundary: exactly one pulse, right after the 4th pop
    step(1'b0, 32'h0, 1'b0, 1'b1);
    for (int k = 0; k < 6; k++) step(1'b1, 32'hD000_0000 + 32'(k), 1'b0);
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      step(1'b0, 32'h0, 1'b1);
      chk("tile_pulse", 32'(m.tileDone), 32'(k == 3));
      if (m.tileDone) pulses++;
    end
    chk("tile_pulses", 32'(pulses), 32'd1);
    chk("tile_rem",    32'(dut.tile_cnt), 32'd2);
    step(1'b0, 32'h0, 1'b0);
    chk("tile_quiet",  32'(m.tileDone), 32'h0);

    // Random traffic against the scoreboard
    for (int k = 0; k < 300; k++)
      step(1'(($urandom % 3) != 0), $urandom, 1'(($urandom % 2) != 0), 1'($urandom_range(0, 60) == 0));

    // Mid-operation async reset with count=3 and overflow set
    step(1'b0, 32'h0, 1'b0, 1'b1);
    for (int k = 0; k < 9; k++) step(1'b1, 32'hE000_0000 + 32'(k), 1'b0);
    for (int k = 0; k < 5; k++) step(1'b0, 32'h0, 1'b1);
    chk("pre_rst_count", 32'(m.count),    32'd3);
    chk("pre_rst_ovf",   32'(m.overflow), 32'h1);
    m.captureEn  = 1'b1;
    m.shiftRegIn = 32'hDEAD_BEEF;
    m.rdEn       = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("arst_count",    32'(m.count),    32'h0);
    chk("arst_valid",    32'(m.valid),    32'h0);
    chk("arst_full",     32'(m.full),     32'h0);
    chk("arst_overflow", 32'(m.overflow), 32'h0);
    chk("arst_tileDone", 32'(m.tileDone), 32'h0);
    chk("arst_bufout",   m.bufferOut,     32'h0);
    model_reset();
    #2 rst = 1'b0;
    idle();
    step(1'b1, 32'h0102_0304, 1'b0);
    chk("post_rst_count", 32'(m.count), 32'd1);
    chk("post_rst_head",  m.bufferOut,  32'h0102_0304);
    idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
